// File: rtl/restador_serial_pkg.sv
// Shared definitions for the serial subtractor: FSM encodings and default width.
package restador_serial_pkg;

  // Default operand/result width; legal range is 2..16.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : restador_serial_pkg

// File: rtl/restador_serial_completo.sv
// 1-bit full subtractor: d = a - b - bin, bout set when the difference goes negative.
module restador_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference is the parity of the three inputs; a borrow is needed when b
  // exceeds a, or when a equals b and a borrow is already pending.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : restador_completo

// File: rtl/restador_serial.sv
// Bit-serial subtractor: computes A - B - borrow-in one bit per cycle, LSB first.
//
// Handshake: a start is accepted only when oBusy is 0 (IDLE) and iStart is 1 at
// a rising edge; operands are captured on that edge. oDone pulses for one cycle
// when oResult/oBorrow/oZero take the new values. iStart while busy is dropped.
module restador_serial
  import restador_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iOpA,
  input  logic [WIDTH-1:0] iOpB,
  input  logic             iBorrow0,
  output logic [WIDTH-1:0] oResult,
  output logic             oBorrow,
  output logic             oZero,
  output logic             oBusy,
  output logic             oDone,
  output state_t           dbg_state
);

  // Counter only needs to reach WIDTH, so it never wraps.
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             shift_en;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             bit_d;
  logic             bit_bout;

  // Single shared full subtractor fed from the operand LSBs and the borrow flop.
  restador_completo u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // State register; reset wins over every transition.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        // The edge that processes the last bit also moves us to DONE.
        if (cnt == LAST) state_next = S_DONE;
      end
      S_DONE: begin
        finish     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign oBusy     = (state != S_IDLE);
  assign dbg_state = state;

  // Operand/result shift registers, borrow flop and bit counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= iOpA;
      b_sr   <= iOpB;
      res_sr <= '0;
      brw    <= iBorrow0;
      cnt    <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      // New bit enters at the MSB so bit 0 ends up in the LSB after WIDTH shifts.
      res_sr <= {bit_d, res_sr[WIDTH-1:1]};
      brw    <= bit_bout;
      cnt    <= cnt + CW'(1);
    end
  end

  // Visible results update only on completion, so shift progress never leaks out.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oResult <= '0;
      oBorrow <= 1'b0;
      oZero   <= 1'b1;
      oDone   <= 1'b0;
    end else begin
      oDone <= finish;
      if (finish) begin
        oResult <= res_sr;
        oBorrow <= brw;
        oZero   <= (res_sr == '0);
      end
    end
  end

endmodule : restador_serial

// File: tb/tb_restador_serial.sv
// Directed self-checking bench for restador_serial at WIDTH=4.
module tb_restador_serial;
  import restador_serial_pkg::*;

  localparam int W  = 4;
  localparam int EW = W + 2;  // {borrow, zero, result}

  logic         Clock;
  logic         Reset;
  logic         iStart;
  logic [W-1:0] iOpA;
  logic [W-1:0] iOpB;
  logic         iBorrow0;
  logic [W-1:0] oResult;
  logic         oBorrow;
  logic         oZero;
  logic         oBusy;
  logic         oDone;
  state_t       dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  restador_serial #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iOpA      (iOpA),
    .iOpB      (iOpB),
    .iBorrow0  (iBorrow0),
    .oResult   (oResult),
    .oBorrow   (oBorrow),
    .oZero     (oZero),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: unsigned A - B - Bin modulo 2^W.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
    int           diff;
    logic [W-1:0] r;
    diff = int'(a) - int'(b) - int'(bin);
    r    = W'(diff);
    return {(diff < 0), (r == '0), r};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Compare the DUT outputs against the oldest queued expectation.
  task automatic score(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 32'(oResult), 32'(e[W-1:0]));
      check({tag, "_zero"},   32'(oZero),   32'(e[W]));
      check({tag, "_borrow"}, 32'(oBorrow), 32'(e[W+1]));
    end
  endtask

  // Launch one operation, wait (bounded) for oDone, check latency and results.
  // Returns in the cycle where oDone is high.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input bit scramble);
    int  n;
    bit  seen;
    iOpA     = a;
    iOpB     = b;
    iBorrow0 = bin;
    iStart   = 1'b1;
    exp_q.push_back(model(a, b, bin));
    step();
    iStart = 1'b0;
    check({tag, "_busy"}, 32'(oBusy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (scramble) begin
        iOpA     = W'($urandom_range(0, 15));
        iOpB     = W'($urandom_range(0, 15));
        iBorrow0 = 1'($urandom_range(0, 1));
      end
      step();
      n++;
      if (oDone) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    score(tag);
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    iStart   = 1'b0;
    iOpA     = '0;
    iOpB     = '0;
    iBorrow0 = 1'b0;
    step();
    step();
    Reset = 1'b0;

    // Reset state.
    check("rst_result", 32'(oResult), 32'd0);
    check("rst_borrow", 32'(oBorrow), 32'd0);
    check("rst_zero",   32'(oZero),   32'd1);
    check("rst_busy",   32'(oBusy),   32'd0);
    check("rst_done",   32'(oDone),   32'd0);
    check("rst_state",  32'(dbg_state), 32'(S_IDLE));
    step();

    // Basic subtractions.
    do_op("op_7m3", 4'd7, 4'd3, 1'b0, 1'b0);
    step();
    check("op_7m3_done_fall", 32'(oDone), 32'd0);
    check("op_7m3_result_hold", 32'(oResult), 32'h4);
    do_op("op_3m7", 4'd3, 4'd7, 1'b0, 1'b0);
    step();
    do_op("op_0m0b1", 4'd0, 4'd0, 1'b1, 1'b0);
    step();

    // Reset during the second SHIFT cycle aborts the operation.
    iOpA   = 4'd9;
    iOpB   = 4'd2;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort_busy",   32'(oBusy),   32'd0);
    check("abort_result", 32'(oResult), 32'd0);
    check("abort_zero",   32'(oZero),   32'd1);
    check("abort_borrow", 32'(oBorrow), 32'd0);
    dones = int'(oDone);
    for (int i = 0; i < 8; i++) begin
      step();
      dones += int'(oDone);
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Fresh operation after abort, then a start in the oDone (IDLE) cycle with
    // operands scrambled during SHIFT.
    do_op("op_9m2", 4'd9, 4'd2, 1'b0, 1'b0);
    check("op_9m2_idle", 32'(oBusy), 32'd0);
    do_op("op_15m1", 4'd15, 4'd1, 1'b0, 1'b1);
    step();

    // Zero result, with iStart held high through the busy cycles.
    iOpA     = 4'd5;
    iOpB     = 4'd5;
    iBorrow0 = 1'b0;
    iStart   = 1'b1;
    exp_q.push_back(model(4'd5, 4'd5, 1'b0));
    step();
    iOpA  = 4'd9;
    iOpB  = 4'd1;
    dones = 0;
    for (int i = 0; i < 20 && dones == 0; i++) begin
      step();
      if (oDone) begin
        iStart = 1'b0;
        dones++;
      end
    end
    iStart = 1'b0;
    check("hold_done_seen", 32'(dones), 32'd1);
    score("hold");
    for (int i = 0; i < 10; i++) begin
      step();
      dones += int'(oDone);
    end
    check("hold_single_done", 32'(dones), 32'd1);
    check("hold_result_kept", 32'(oResult), 32'd0);
    check("hold_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_restador_serial
